// File: rtl/packet_switch_pkg.sv
// Shared types for the packet-switch AVMM CSR initiator: FSM states and response status codes.
package packet_switch_pkg;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_REQ     = 2'd1,
      S_WAIT_RD = 2'd2,
      S_RESP    = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      RSP_OK        = 2'd0,
      RSP_RANGE_ERR = 2'd1,
      RSP_TIMEOUT   = 2'd2
   } rsp_status_t;

   localparam logic [7:0] STRAY_MAX = 8'hFF;

   // Window check done in 33 bits so base+size cannot wrap.
   function automatic logic addr_in_window(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input logic [31:0] size);
      logic [32:0] lim;
      lim = {1'b0, base} + {1'b0, size};
      return (addr >= base) && ({1'b0, addr} < lim);
   endfunction

endpackage

// File: rtl/packet_switch_avmm_rsp_timer.sv
// Transaction timeout timer: down-counter loaded on clear, expires at terminal count zero.
module packet_switch_avmm_rsp_timer #(
   parameter int TIMEOUT_CYC = 64
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT_CYC);
   localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYC - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= LOAD;
      end else if (en && (cnt != '0)) begin
         cnt <= cnt - CW'(1);
      end
   end

   // Zero is reached in the TIMEOUT_CYC-th enabled cycle after a clear.
   assign expired = (cnt == '0);

endmodule

// File: rtl/packet_switch_avmm_csr_initiator.sv
// Single-outstanding AVMM initiator: one command in, one bus cycle (if in range), one response out.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   S_IDLE    | cmd_ready high, waiting for a command
//   S_REQ     | avmm_read/avmm_write asserted, held while waitrequest
//   S_WAIT_RD | read accepted, waiting for readdata_valid
//   S_RESP    | rsp_valid high, waiting for rsp_ready
module packet_switch_avmm_csr_initiator
   import packet_switch_pkg::*;
#(
   parameter int BASE_ADDR   = 'h0,
   parameter int MAX_ADDR    = 'h8,
   parameter int ADDR_WIDTH  = 8,
   parameter int DATA_WIDTH  = 32,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic                    clk,
   input  logic                    rst_n,

   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [ADDR_WIDTH-1:0]   cmd_address,
   input  logic [DATA_WIDTH-1:0]   cmd_writedata,
   input  logic [DATA_WIDTH/8-1:0] cmd_byteenable,

   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [DATA_WIDTH-1:0]   rsp_readdata,
   output logic [1:0]              rsp_status,

   output logic [ADDR_WIDTH-1:0]   avmm_address,
   output logic                    avmm_read,
   output logic                    avmm_write,
   output logic [DATA_WIDTH-1:0]   avmm_writedata,
   output logic [DATA_WIDTH/8-1:0] avmm_byteenable,
   input  logic                    avmm_waitrequest,
   input  logic [DATA_WIDTH-1:0]   avmm_readdata,
   input  logic                    avmm_readdata_valid,

   output logic [7:0]              stray_rdv_cnt,
   output logic                    busy
);

   state_t                  state, state_next;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic [DATA_WIDTH/8-1:0] be_q;
   logic                    write_q;
   logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
   rsp_status_t             rsp_status_q, rsp_status_d;
   logic [7:0]              stray_q;
   logic                    cmd_ready_q;

   logic load_cmd, set_rsp, stray_hit;
   logic timer_clr, timer_en, timer_expired;
   logic cmd_in_range;

   assign cmd_in_range = addr_in_window(32'(cmd_address), 32'(BASE_ADDR), 32'(MAX_ADDR));

   packet_switch_avmm_rsp_timer #(
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (timer_clr),
      .en      (timer_en),
      .expired (timer_expired)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next   = state;
      load_cmd     = 1'b0;
      set_rsp      = 1'b0;
      stray_hit    = 1'b0;
      timer_clr    = 1'b0;
      rsp_data_d   = '0;
      rsp_status_d = RSP_OK;
      timer_en     = (state == S_REQ) || (state == S_WAIT_RD);

      unique case (state)
         S_IDLE: begin
            stray_hit = avmm_readdata_valid;
            if (cmd_valid && cmd_ready_q) begin
               load_cmd = 1'b1;
               if (cmd_in_range) begin
                  state_next = S_REQ;
                  timer_clr  = 1'b1;
               end else begin
                  state_next   = S_RESP;
                  set_rsp      = 1'b1;
                  rsp_status_d = RSP_RANGE_ERR;
               end
            end
         end
         S_REQ: begin
            if (write_q) begin
               stray_hit = avmm_readdata_valid;
               if (!avmm_waitrequest) begin
                  state_next = S_RESP;
                  set_rsp    = 1'b1;
               end else if (timer_expired) begin
                  state_next   = S_RESP;
                  set_rsp      = 1'b1;
                  rsp_status_d = RSP_TIMEOUT;
               end
            end else begin
               // Data arriving with the accept wins over a coincident expiry.
               if (!avmm_waitrequest && avmm_readdata_valid) begin
                  state_next = S_RESP;
                  set_rsp    = 1'b1;
                  rsp_data_d = avmm_readdata;
               end else if (timer_expired) begin
                  state_next   = S_RESP;
                  set_rsp      = 1'b1;
                  rsp_status_d = RSP_TIMEOUT;
               end else if (!avmm_waitrequest) begin
                  state_next = S_WAIT_RD;
               end
            end
         end
         S_WAIT_RD: begin
            if (avmm_readdata_valid) begin
               state_next = S_RESP;
               set_rsp    = 1'b1;
               rsp_data_d = avmm_readdata;
            end else if (timer_expired) begin
               state_next   = S_RESP;
               set_rsp      = 1'b1;
               rsp_status_d = RSP_TIMEOUT;
            end
         end
         S_RESP: begin
            stray_hit = avmm_readdata_valid;
            if (rsp_ready) begin
               state_next = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q       <= '0;
         wdata_q      <= '0;
         be_q         <= '0;
         write_q      <= 1'b0;
         rsp_data_q   <= '0;
         rsp_status_q <= RSP_OK;
         stray_q      <= '0;
         cmd_ready_q  <= 1'b0;
      end else begin
         if (load_cmd) begin
            addr_q  <= cmd_address;
            wdata_q <= cmd_writedata;
            be_q    <= cmd_byteenable;
            write_q <= cmd_write;
         end
         if (set_rsp) begin
            rsp_data_q   <= rsp_data_d;
            rsp_status_q <= rsp_status_d;
         end
         if (stray_hit && (stray_q != STRAY_MAX)) begin
            stray_q <= stray_q + 8'd1;
         end
         cmd_ready_q <= (state_next == S_IDLE);
      end
   end

   assign cmd_ready       = cmd_ready_q;
   assign rsp_valid       = (state == S_RESP);
   assign rsp_readdata    = rsp_data_q;
   assign rsp_status      = rsp_status_q;
   assign avmm_address    = addr_q;
   assign avmm_writedata  = wdata_q;
   assign avmm_byteenable = be_q;
   assign avmm_read       = (state == S_REQ) && !write_q;
   assign avmm_write      = (state == S_REQ) && write_q;
   assign stray_rdv_cnt   = stray_q;
   assign busy            = (state != S_IDLE);

endmodule

// File: tb/tb_packet_switch_avmm_csr_initiator.sv
// Directed and randomized checks of the AVMM CSR initiator against a cycle-count reference model.
module tb_packet_switch_avmm_csr_initiator;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [7:0]  cmd_address;
   logic [31:0] cmd_writedata;
   logic [3:0]  cmd_byteenable;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_readdata;
   logic [1:0]  rsp_status;
   logic [7:0]  avmm_address;
   logic        avmm_read, avmm_write;
   logic [31:0] avmm_writedata;
   logic [3:0]  avmm_byteenable;
   logic        avmm_waitrequest;
   logic [31:0] avmm_readdata;
   logic        avmm_readdata_valid;
   logic [7:0]  stray_rdv_cnt;
   logic        busy;

   int n_vec = 0;
   int n_err = 0;
   int stray_exp = 0;

   always #5 clk = ~clk;

   packet_switch_avmm_csr_initiator dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .cmd_valid           (cmd_valid),
      .cmd_ready           (cmd_ready),
      .cmd_write           (cmd_write),
      .cmd_address         (cmd_address),
      .cmd_writedata       (cmd_writedata),
      .cmd_byteenable      (cmd_byteenable),
      .rsp_valid           (rsp_valid),
      .rsp_ready           (rsp_ready),
      .rsp_readdata        (rsp_readdata),
      .rsp_status          (rsp_status),
      .avmm_address        (avmm_address),
      .avmm_read           (avmm_read),
      .avmm_write          (avmm_write),
      .avmm_writedata      (avmm_writedata),
      .avmm_byteenable     (avmm_byteenable),
      .avmm_waitrequest    (avmm_waitrequest),
      .avmm_readdata       (avmm_readdata),
      .avmm_readdata_valid (avmm_readdata_valid),
      .stray_rdv_cnt       (stray_rdv_cnt),
      .busy                (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: window [0,8), timeout after 64 bus cycles. Cycle k=1 is the first
   // cycle after the accepting edge; waitrequest is high for k<=wr_wait and a single
   // readdata_valid pulse (if rdv_k>0) lands in cycle rdv_k. Response held d extra cycles.
   task automatic run_txn(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                          input logic [3:0] be, input int wr_wait, input int rdv_k,
                          input logic [31:0] rd_data, input int d);
      logic        in_rng, done_ok, hs;
      int          strobe_n, rsp_k, k;
      logic [1:0]  st;
      logic [31:0] data_exp;
      in_rng   = (addr < 8'd8);
      done_ok  = !wr && in_rng && (wr_wait < 64) && (rdv_k >= wr_wait + 1) && (rdv_k <= 64);
      strobe_n = !in_rng ? 0 : ((wr_wait < 64) ? wr_wait + 1 : 64);
      data_exp = 32'h0;
      if (!in_rng) begin
         rsp_k = 1;  st = 2'd1;
      end else if (wr) begin
         if (wr_wait < 64) begin rsp_k = wr_wait + 2; st = 2'd0; end
         else begin rsp_k = 65; st = 2'd2; end
      end else if (done_ok) begin
         rsp_k = rdv_k + 1; st = 2'd0; data_exp = rd_data;
      end else begin
         rsp_k = 65; st = 2'd2;
      end

      @(negedge clk);
      cmd_write      = wr;
      cmd_address    = addr;
      cmd_writedata  = wd;
      cmd_byteenable = be;
      cmd_valid      = 1'b1;
      chk("cmd_ready_before_accept", 32'(cmd_ready), 32'(1));
      @(posedge clk);
      k  = 0;
      hs = 1'b0;
      while (!hs) begin
         @(negedge clk);
         k++;
         cmd_valid           = 1'b0;
         cmd_writedata       = $urandom;
         avmm_waitrequest    = (k <= wr_wait);
         avmm_readdata_valid = (k == rdv_k);
         avmm_readdata       = (k == rdv_k) ? rd_data : $urandom;
         rsp_ready           = (k >= rsp_k + d);
         if ((k == rdv_k) && !done_ok && (stray_exp < 255)) stray_exp++;
         chk("avmm_read",  32'(avmm_read),  32'(!wr && (k <= strobe_n)));
         chk("avmm_write", 32'(avmm_write), 32'(wr && (k <= strobe_n)));
         if (k <= strobe_n) begin
            chk("avmm_address", 32'(avmm_address), 32'(addr));
            if (wr) begin
               chk("avmm_writedata",  avmm_writedata, wd);
               chk("avmm_byteenable", 32'(avmm_byteenable), 32'(be));
            end
         end
         chk("rsp_valid", 32'(rsp_valid), 32'(k >= rsp_k));
         chk("busy_in_txn", 32'(busy), 32'(1));
         chk("cmd_ready_in_txn", 32'(cmd_ready), 32'(0));
         if (k >= rsp_k) begin
            chk("rsp_status",   32'(rsp_status), 32'(st));
            chk("rsp_readdata", rsp_readdata, data_exp);
         end
         if (k == rsp_k + d) hs = 1'b1;
         if (k > 200) begin
            chk("txn_cycle_budget", 32'(k), 32'(rsp_k + d));
            hs = 1'b1;
         end
      end
      @(negedge clk);
      avmm_readdata_valid = 1'b0;
      avmm_waitrequest    = 1'b0;
      rsp_ready           = 1'b0;
      chk("cmd_ready_after_rsp", 32'(cmd_ready), 32'(1));
      chk("busy_after_rsp",      32'(busy),      32'(0));
      chk("rsp_valid_after_rsp", 32'(rsp_valid), 32'(0));
      chk("stray_cnt",           32'(stray_rdv_cnt), 32'(stray_exp));
   endtask

   task automatic stray_pulse();
      @(negedge clk);
      avmm_readdata_valid = 1'b1;
      avmm_readdata       = $urandom;
      if (stray_exp < 255) stray_exp++;
      @(negedge clk);
      avmm_readdata_valid = 1'b0;
      chk("stray_cnt_idle", 32'(stray_rdv_cnt), 32'(stray_exp));
   endtask

   initial begin
      logic        wr;
      logic [7:0]  addr;
      logic [31:0] wd, rd;
      logic [3:0]  be;
      int          ww, rk, d, lim;

      rst_n               = 1'b0;
      cmd_valid           = 1'b0;
      cmd_write           = 1'b0;
      cmd_address         = '0;
      cmd_writedata       = '0;
      cmd_byteenable      = '0;
      rsp_ready           = 1'b0;
      avmm_waitrequest    = 1'b0;
      avmm_readdata       = '0;
      avmm_readdata_valid = 1'b0;

      #1;
      chk("rst_cmd_ready",  32'(cmd_ready),  32'(0));
      chk("rst_rsp_valid",  32'(rsp_valid),  32'(0));
      chk("rst_rsp_status", 32'(rsp_status), 32'(0));
      chk("rst_rsp_data",   rsp_readdata,    32'h0);
      chk("rst_avmm_read",  32'(avmm_read),  32'(0));
      chk("rst_avmm_write", 32'(avmm_write), 32'(0));
      chk("rst_avmm_addr",  32'(avmm_address), 32'(0));
      chk("rst_stray",      32'(stray_rdv_cnt), 32'(0));
      chk("rst_busy",       32'(busy),       32'(0));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      chk("ready_before_first_edge", 32'(cmd_ready), 32'(0));
      @(posedge clk);
      #1;
      chk("ready_after_first_edge", 32'(cmd_ready), 32'(1));

      run_txn(1'b1, 8'h04, 32'hA5A5_0001, 4'hF, 0, 0, 32'h0, 0);
      run_txn(1'b0, 8'h00, 32'h0, 4'hF, 0, 2, 32'h0000_1234, 0);
      run_txn(1'b0, 8'h08, 32'h0, 4'hF, 0, 0, 32'h0, 0);
      run_txn(1'b1, 8'h07, 32'h1357_9BDF, 4'h5, 3, 0, 32'h0, 1);
      run_txn(1'b0, 8'h03, 32'h0, 4'hF, 0, 0, 32'h0, 0);
      repeat (9) @(negedge clk);
      stray_pulse();
      run_txn(1'b0, 8'h03, 32'h0, 4'hF, 1, 3, 32'hBEEF_0042, 0);
      run_txn(1'b0, 8'h05, 32'h0, 4'hF, 0, 64, 32'hCAFE_F00D, 1);
      run_txn(1'b0, 8'h05, 32'h0, 4'hF, 0, 65, 32'hDEAD_0001, 1);
      run_txn(1'b0, 8'h06, 32'h0, 4'hF, 63, 64, 32'h0BAD_CAFE, 0);
      run_txn(1'b1, 8'h02, 32'h2222_3333, 4'h3, 64, 10, 32'h0, 0);
      run_txn(1'b1, 8'h01, 32'h4444_5555, 4'hC, 2, 2, 32'h0, 0);

      for (int i = 0; i < 40; i++) begin
         wr   = 1'($urandom);
         addr = 8'($urandom_range(0, 11));
         wd   = $urandom;
         rd   = $urandom;
         be   = 4'($urandom);
         ww   = ($urandom_range(0, 7) == 0) ? 64 + int'($urandom_range(0, 2)) : int'($urandom_range(0, 3));
         d    = int'($urandom_range(0, 2));
         if (wr) begin
            lim = (ww < 64) ? ww + 1 : 64;
            rk  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, lim)) : 0;
         end else begin
            rk  = ($urandom_range(0, 5) == 0) ? 0 : ww + 1 + int'($urandom_range(0, 4));
         end
         run_txn(wr, addr, wd, be, ww, rk, rd, d);
      end

      for (int i = 0; i < 260; i++) stray_pulse();
      chk("stray_saturated", 32'(stray_rdv_cnt), 32'(255));

      @(negedge clk);
      cmd_write   = 1'b0;
      cmd_address = 8'h02;
      cmd_valid   = 1'b1;
      chk("mid_rst_ready", 32'(cmd_ready), 32'(1));
      @(posedge clk);
      @(negedge clk);
      cmd_valid        = 1'b0;
      avmm_waitrequest = 1'b0;
      @(negedge clk);
      chk("mid_rst_busy_before", 32'(busy), 32'(1));
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_avmm_read",  32'(avmm_read),  32'(0));
      chk("mid_rst_avmm_write", 32'(avmm_write), 32'(0));
      chk("mid_rst_rsp_valid",  32'(rsp_valid),  32'(0));
      chk("mid_rst_busy",       32'(busy),       32'(0));
      chk("mid_rst_cmd_ready",  32'(cmd_ready),  32'(0));
      chk("mid_rst_stray",      32'(stray_rdv_cnt), 32'(0));
      stray_exp = 0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("post_rst_ready_before_edge", 32'(cmd_ready), 32'(0));
      @(posedge clk);
      #1;
      chk("post_rst_ready_after_edge", 32'(cmd_ready), 32'(1));

      run_txn(1'b0, 8'h07, 32'h0, 4'hF, 0, 1, 32'h7777_8888, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
